// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 instruction-memory loader.
package y86_pkg;

  localparam int unsigned LEN_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_HDR_HI = 3'd2,
    ST_LOAD   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } ld_state_t;

endpackage

// File: rtl/imem_loader_ctrl.sv
// Loader FSM: frame parsing, length bound check and running XOR checksum.
module imem_loader_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  input  logic [LEN_W-1:0] byte_count,
  output logic             in_ready,
  output logic             load_wr,
  output logic             load_start,
  output logic             done,
  output logic             err,
  output logic             core_run
);

  ld_state_t        state;
  ld_state_t        next_state;
  logic [LEN_W-1:0] len;
  logic [7:0]       csum;
  logic             xfer;
  logic [LEN_W-1:0] hdr_len;

  assign xfer    = in_valid && in_ready;
  assign hdr_len = {in_byte, len[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) next_state = ST_HDR_LO;
      end
      ST_HDR_LO: begin
        if (xfer) next_state = ST_HDR_HI;
      end
      ST_HDR_HI: begin
        if (xfer) begin
          if (hdr_len == '0 || 32'(hdr_len) > MEM_BYTES) next_state = ST_ERR;
          else                                           next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // byte_count is the pre-increment value, so the last byte is at len-1.
        if (xfer && (byte_count + LEN_W'(1)) == len) next_state = ST_CSUM;
      end
      ST_CSUM: begin
        if (xfer) next_state = (in_byte == csum) ? ST_DONE : ST_ERR;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    load_wr    = 1'b0;
    load_start = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    core_run   = 1'b0;
    case (state)
      ST_IDLE:   load_start = start;
      ST_HDR_LO: in_ready = 1'b1;
      ST_HDR_HI: in_ready = 1'b1;
      ST_LOAD: begin
        in_ready = 1'b1;
        load_wr  = in_valid;
      end
      ST_CSUM:   in_ready = 1'b1;
      ST_DONE: begin
        done       = 1'b1;
        core_run   = 1'b1;
        load_start = start;
      end
      ST_ERR: begin
        err        = 1'b1;
        load_start = start;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len  <= '0;
      csum <= '0;
    end else begin
      if (load_start) csum <= '0;
      if (xfer && state == ST_HDR_LO) len[7:0]  <= in_byte;
      if (xfer && state == ST_HDR_HI) len[15:8] <= in_byte;
      if (load_wr) csum <= csum ^ in_byte;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a framed program image into instruction memory, one registered
// byte write per payload byte, and releases the core only after a good load.
module imem_loader
  import y86_pkg::*;
#(
  parameter int unsigned      MEM_BYTES = 1024,
  parameter int unsigned      ADDR_W    = 64,
  parameter longint unsigned  BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [15:0]       byte_count,
  output logic              core_run,
  output logic              done,
  output logic              err
);

  logic load_wr;
  logic load_start;

  imem_loader_ctrl #(
    .MEM_BYTES(MEM_BYTES)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .byte_count (byte_count),
    .in_ready   (in_ready),
    .load_wr    (load_wr),
    .load_start (load_start),
    .done       (done),
    .err        (err),
    .core_run   (core_run)
  );

  // Address/data hold their last value between writes; only mem_we pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we     <= 1'b0;
      mem_addr   <= ADDR_W'(BASE_ADDR);
      mem_wdata  <= '0;
      byte_count <= '0;
    end else begin
      mem_we <= load_wr;
      if (load_start) begin
        byte_count <= '0;
      end else if (load_wr) begin
        mem_addr   <= ADDR_W'(BASE_ADDR) + ADDR_W'(byte_count);
        mem_wdata  <= in_byte;
        byte_count <= byte_count + 16'd1;
      end
    end
  end

endmodule
